// File: rtl/egg_timer_countdown.sv
// Egg-timer core: holds MM:SS as four BCD digits, counts it down once per second,
// and time-multiplexes the digits onto one BCD bus with active-low anode selects.
module egg_timer_countdown #(
    parameter int TICK_DIV = 100000000,
    parameter int MUX_DIV  = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        inc_min,
    input  logic        inc_sec,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an,
    output logic [15:0] time_bcd,
    output logic        running,
    output logic        done
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = $clog2(MUX_DIV);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] REFRESH_LAST = MW'(MUX_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    time_q, time_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [MW-1:0]  refresh_q, refresh_d;
    logic [1:0]     idx_q, idx_d;
    logic [3:0]     an_q, an_d;
    logic [3:0]     bcd_q, bcd_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic [15:0]    incTime;
    logic [15:0]    decTimeVal;

    // Borrow ripples S0 -> S1 -> M0 -> M1; S1 wraps to 5 so seconds stay 00..59.
    function automatic logic [15:0] decTime(input logic [15:0] t);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = t;
        if (s0 != 4'd0) begin
            s0 = s0 - 4'd1;
        end else begin
            s0 = 4'd9;
            if (s1 != 4'd0) begin
                s1 = s1 - 4'd1;
            end else begin
                s1 = 4'd5;
                if (m0 != 4'd0) begin
                    m0 = m0 - 4'd1;
                end else begin
                    m0 = 4'd9;
                    m1 = (m1 != 4'd0) ? m1 - 4'd1 : 4'd9;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    function automatic logic [15:0] incSec(input logic [15:0] t);
        logic [3:0] s1, s0;
        {s1, s0} = t[7:0];
        if (s0 == 4'd9) begin
            s0 = 4'd0;
            s1 = (s1 == 4'd5) ? 4'd0 : s1 + 4'd1;
        end else begin
            s0 = s0 + 4'd1;
        end
        return {t[15:8], s1, s0};
    endfunction

    function automatic logic [15:0] incMin(input logic [15:0] t);
        logic [3:0] m1, m0;
        {m1, m0} = t[15:8];
        if (m0 == 4'd9) begin
            m0 = 4'd0;
            m1 = (m1 == 4'd9) ? 4'd0 : m1 + 4'd1;
        end else begin
            m0 = m0 + 4'd1;
        end
        return {m1, m0, t[7:0]};
    endfunction

    // Priority: clear, then start_stop, then the one-second tick, then the set buttons.
    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        presc_d    = presc_q;
        incTime    = time_q;
        decTimeVal = decTime(time_q);
        if (inc_sec) incTime = incSec(incTime);
        if (inc_min) incTime = incMin(incTime);

        if (clear) begin
            state_d = IDLE;
            time_d  = 16'h0000;
            presc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        if (time_q != 16'h0000) begin
                            state_d = RUN;
                            presc_d = '0;
                        end
                    end else begin
                        time_d = incTime;
                    end
                end
                RUN: begin
                    if (start_stop) begin
                        state_d = PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        time_d  = decTimeVal;
                        if (decTimeVal == 16'h0000) state_d = DONE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (start_stop) begin
                        state_d = (time_q == 16'h0000) ? IDLE : RUN;
                    end else begin
                        time_d = incTime;
                    end
                end
                DONE: begin
                    if (start_stop) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    // The display path reads registered index and time, so an/bcd_out lag the index by one edge.
    always_comb begin
        refresh_d = (refresh_q == REFRESH_LAST) ? '0 : refresh_q + MW'(1);
        idx_d     = (refresh_q == REFRESH_LAST) ? idx_q + 2'd1 : idx_q;
        an_d      = ~(4'b0001 << idx_q);
        case (idx_q)
            2'd0:    bcd_d = time_q[3:0];
            2'd1:    bcd_d = time_q[7:4];
            2'd2:    bcd_d = time_q[11:8];
            default: bcd_d = time_q[15:12];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            time_q    <= 16'h0000;
            presc_q   <= '0;
            refresh_q <= '0;
            idx_q     <= 2'd0;
            an_q      <= 4'b1110;
            bcd_q     <= 4'd0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            time_q    <= time_d;
            presc_q   <= presc_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            bcd_q     <= bcd_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign bcd_out  = bcd_q;
    assign an       = an_q;
    assign time_bcd = time_q;
    assign running  = running_q;
    assign done     = done_q;

endmodule

// File: tb/tb_egg_timer_countdown.sv
// Scoreboard bench for egg_timer_countdown: a seconds-based reference model predicts
// every cycle's outputs, and a separate monitor pops and compares them after each edge.
module tb_egg_timer_countdown;

    localparam int TICK_DIV = 4;
    localparam int MUX_DIV  = 2;

    localparam int ST_IDLE  = 0;
    localparam int ST_RUN   = 1;
    localparam int ST_PAUSE = 2;
    localparam int ST_DONE  = 3;

    logic        clk;
    logic        rst_n;
    logic        start_stop;
    logic        clear;
    logic        inc_min;
    logic        inc_sec;
    logic [3:0]  bcd_out;
    logic [3:0]  an;
    logic [15:0] time_bcd;
    logic        running;
    logic        done;

    typedef struct {
        logic [15:0] t;
        logic [3:0]  a;
        logic [3:0]  b;
        logic        r;
        logic        d;
    } exp_t;

    exp_t expQ[$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: plain minutes/seconds integers and a cycle count since reset.
    int mState;
    int mMin;
    int mSec;
    int mPresc;
    int mEdges;

    egg_timer_countdown #(
        .TICK_DIV(TICK_DIV),
        .MUX_DIV (MUX_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .clear     (clear),
        .inc_min   (inc_min),
        .inc_sec   (inc_sec),
        .bcd_out   (bcd_out),
        .an        (an),
        .time_bcd  (time_bcd),
        .running   (running),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] toBcd(input int mn, input int sc);
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
    endfunction

    function automatic logic [3:0] digitOf(input int mn, input int sc, input int idx);
        case (idx)
            0:       return 4'(sc % 10);
            1:       return 4'(sc / 10);
            2:       return 4'(mn % 10);
            default: return 4'(mn / 10);
        endcase
    endfunction

    // Advance the model by one clock edge for the given pulses and queue the outcome.
    task automatic modelStep(input bit ss, input bit clr, input bit im, input bit is);
        exp_t e;
        int   idxPrev;
        int   total;
        mEdges++;
        idxPrev = ((mEdges - 1) / MUX_DIV) % 4;
        e.a = 4'hF & ~(4'b0001 << idxPrev);
        e.b = digitOf(mMin, mSec, idxPrev);
        total = mMin * 60 + mSec;
        if (clr) begin
            mState = ST_IDLE;
            mMin   = 0;
            mSec   = 0;
            mPresc = 0;
        end else begin
            case (mState)
                ST_IDLE: begin
                    if (ss) begin
                        if (total != 0) begin
                            mState = ST_RUN;
                            mPresc = 0;
                        end
                    end else begin
                        if (is) mSec = (mSec + 1) % 60;
                        if (im) mMin = (mMin + 1) % 100;
                    end
                end
                ST_RUN: begin
                    if (ss) begin
                        mState = ST_PAUSE;
                    end else if (mPresc == TICK_DIV - 1) begin
                        mPresc = 0;
                        total  = total - 1;
                        mMin   = total / 60;
                        mSec   = total % 60;
                        if (total == 0) mState = ST_DONE;
                    end else begin
                        mPresc++;
                    end
                end
                ST_PAUSE: begin
                    if (ss) begin
                        mState = (total == 0) ? ST_IDLE : ST_RUN;
                    end else begin
                        if (is) mSec = (mSec + 1) % 60;
                        if (im) mMin = (mMin + 1) % 100;
                    end
                end
                default: begin
                    if (ss) mState = ST_IDLE;
                end
            endcase
        end
        e.t = toBcd(mMin, mSec);
        e.r = (mState == ST_RUN);
        e.d = (mState == ST_DONE);
        expQ.push_back(e);
    endtask

    // Called at a falling edge; drives one cycle of pulses and returns at the next falling edge.
    task automatic applyStimulus(input bit ss, input bit clr, input bit im, input bit is);
        start_stop = ss;
        clear      = clr;
        inc_min    = im;
        inc_sec    = is;
        modelStep(ss, clr, im, is);
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic setTime(input int mn, input int sc);
        for (int i = 0; i < mn; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < sc; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic checkOutput(input string name, input exp_t e);
        vectors++;
        if (time_bcd !== e.t || an !== e.a || bcd_out !== e.b ||
            running !== e.r || done !== e.d) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got time=%h an=%b bcd=%h run=%b done=%b, want time=%h an=%b bcd=%h run=%b done=%b",
                     name, $time, time_bcd, an, bcd_out, running, done,
                     e.t, e.a, e.b, e.r, e.d);
        end
    endtask

    // Asynchronous reset between edges: outputs must already be at reset values 1 time unit later.
    task automatic resetDut();
        exp_t e;
        rst_n = 1'b0;
        #1;
        e.t = 16'h0000;
        e.a = 4'b1110;
        e.b = 4'h0;
        e.r = 1'b0;
        e.d = 1'b0;
        checkOutput("reset", e);
        mState = ST_IDLE;
        mMin   = 0;
        mSec   = 0;
        mPresc = 0;
        mEdges = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every edge that has a queued prediction is compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("cycle", e);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        inc_min    = 1'b0;
        inc_sec    = 1'b0;
        mState     = ST_IDLE;
        mMin       = 0;
        mSec       = 0;
        mPresc     = 0;
        mEdges     = 0;
        @(negedge clk);
        resetDut();

        // Setting, including the 59 -> 00 seconds wrap.
        setTime(2, 5);
        setTime(0, 60);
        idle(2);

        // Full countdown from 01:00 into DONE.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        setTime(1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(245);

        // Pause mid-second, hold, resume with the fraction kept.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        setTime(0, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(20);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(6);

        // Clear beats start_stop; start_stop at 00:00 is ignored.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        setTime(10, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // Display scan at 12:34, and minutes 99 -> 00 wrap.
        setTime(12, 34);
        idle(16);
        setTime(88, 0);
        idle(2);

        // Reset mid-run at 05:17.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        setTime(5, 17);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        idle(5);
        resetDut();
        idle(4);

        // Randomized pulses, with occasional short countdowns and resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 999) == 0) begin
                resetDut();
            end else if ($urandom_range(0, 299) == 0) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
                setTime(0, $urandom_range(1, 4));
                applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            end else begin
                applyStimulus($urandom_range(0, 99) < 5,
                              $urandom_range(0, 199) == 0,
                              $urandom_range(0, 9) == 0,
                              $urandom_range(0, 5) == 0);
            end
        end

        @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d predictions left unchecked, want 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
